// File: rtl/pe_result_drain.sv
// pe_result_drain: tail collector for the PE systolic chain.
// Captures results from the last PE, which cannot be stalled, into a small FIFO.
// Each word is width-converted as it is pushed. Words leave through a registered
// AXI-Stream master stage, with tlast marking every FRAME_LEN beats. A flush
// cuts the current frame short at the last buffered word.
// Optional build macro: PE_DRAIN_SAT_EN. When it is defined, narrowing saturates;
// otherwise narrowing truncates.
module pe_result_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 1,
    parameter int OUT_WIDTH    = 8,
    parameter int FRAME_LEN    = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [DATA_WIDTH+WEIGHT_WIDTH:0]    in_result,
    input  logic                                in_valid,
    output logic [OUT_WIDTH-1:0]                m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic                                frame_done,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

    localparam int RW = DATA_WIDTH + WEIGHT_WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (RW > OUT_WIDTH) ? RW : OUT_WIDTH;
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 state;
    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_valid;
    logic                   out_last;
    logic [BW-1:0]          beat_cnt;
    logic                   overflow_q;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   drop;
    logic                   hs;
    logic                   load;
    logic [BW-1:0]          cnt_after;
    logic                   next_last;
    logic [OUT_WIDTH-1:0]   conv_word;

    // Zero-extend, then narrow. Narrowing either truncates or clamps to the
    // largest value OUT_WIDTH bits can hold.
    function automatic logic [OUT_WIDTH-1:0] convert(input logic [RW-1:0] v);
        logic [XW-1:0] ext;
        ext = XW'(v);
`ifdef PE_DRAIN_SAT_EN
        if ((ext >> OUT_WIDTH) != '0) begin
            return '1;
        end
`endif
        return ext[OUT_WIDTH-1:0];
    endfunction

    // Push/pop qualification and the tlast decision for the word entering the output register.
    always_comb begin
        // NOTE: every signal assigned here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        cnt_after = beat_cnt;
        next_last = 1'b0;
        full      = (count == CW'(FIFO_DEPTH));
        empty     = (count == '0);
        // Full is judged on the registered count, so a same-cycle pop cannot make room.
        push      = (state == RUN) && in_valid && !full;
        drop      = (state == RUN) && in_valid && full;
        hs        = out_valid && m_axis_tready;
        load      = !empty && (!out_valid || hs);
        conv_word = convert(in_result);
        // This is the beat index the newly loaded word will carry, after any handshake this cycle.
        if (hs) begin
            cnt_after = out_last ? '0 : beat_cnt + 1'b1;
        end
        // Nothing is pushed in FLUSH, so a single entry is the final buffered word.
        next_last = (cnt_after == BW'(FRAME_LEN - 1)) ||
                    ((state == FLUSH) && (count == CW'(1)));
    end

    // Mode sequencing: accept while enabled, then drain until nothing is left.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from values sampled before the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= FLUSH;
                FLUSH: begin
                    if (enable)                  state <= RUN;
                    else if (empty && !out_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and exact occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(load);
        end
    end

    // FIFO storage, written with the already-converted word.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Clearing the pointers and the count
        // is enough to make stale contents unreachable.
        if (push) begin
            mem[wr_ptr] <= conv_word;
        end
    end

    // Output register: refilled when empty or on handshake; otherwise data and tlast are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            out_last  <= next_last;
        end else if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Beat counter and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (hs) beat_cnt <= cnt_after;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign frame_done    = hs && out_last;
    assign overflow      = overflow_q;
    assign fifo_count    = count;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain. The stimulus pushes the expected beats into a
// queue. A negedge monitor pops and compares every beat the DUT presents. It
// also checks AXIS hold rules and the frame_done pulse.
module tb_pe_result_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] in_result;
    logic       in_valid;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       frame_done;
    logic       overflow;
    logic [3:0] fifo_count;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    checks     = 0;
    int    failures   = 0;
    int    beats_seen = 0;
    int    mcnt       = 0;

    pe_result_drain dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in_result     (in_result),
        .in_valid      (in_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue one expected beat. The frame position comes from the bench's own beat model.
    task automatic expect_word(input logic [7:0] d, input logic force_last);
        logic l;
        l = force_last || (mcnt == 15);
        sb.push_back('{data: d, last: l});
        mcnt = l ? 0 : mcnt + 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        next_cycle();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 300) begin
            next_cycle();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: scoreboard compare on every handshake, plus AXIS stability checks.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = '0;
    logic       last_prev  = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_tdata", m_axis_tdata, data_prev);
                check("hold_tlast", m_axis_tlast, last_prev);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_beat: got tdata %0h with no beat expected", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    check("beat_tdata", m_axis_tdata, e.data);
                    check("beat_tlast", m_axis_tlast, e.last);
                    check("beat_frame_done", frame_done, e.last);
                end
            end else begin
                check("idle_frame_done", frame_done, 0);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            data_prev  = m_axis_tdata;
            last_prev  = m_axis_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_axis_tready = 1'b1;

        // 1: reset values
        do_reset(2);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fifo_count", fifo_count, 0);

        // 2: full frame of 16 beats. First tvalid appears 2 cycles after the first in_valid.
        start_run();
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(i);
            expect_word(8'(i), 1'b0);
            @(negedge clk);
            if (i < 4) check("latency_tvalid", m_axis_tvalid, (i >= 2) ? 1 : 0);
            next_cycle();
        end
        in_valid = 1'b0;
        wait_drain("t2_drained");

        // 3: overflow. Nine words are retained and three are dropped.
        do_reset(1);
        m_axis_tready = 1'b0;
        start_run();
        for (int i = 1; i <= 12; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(i);
            if (i <= 9) expect_word(8'(i), 1'b0);
            next_cycle();
            if (i == 9) check("t3_no_overflow_yet", overflow, 0);
        end
        in_valid = 1'b0;
        check("t3_overflow", overflow, 1);
        check("t3_fifo_count", fifo_count, 8);
        check("t3_head_tdata", m_axis_tdata, 1);
        m_axis_tready = 1'b1;
        wait_drain("t3_drained");
        check("t3_overflow_sticky", overflow, 1);
        check("t3_fifo_empty", fifo_count, 0);

        // 4: conversion of values wider than OUT_WIDTH
        do_reset(1);
        start_run();
        in_valid  = 1'b1;
        in_result = 10'h3FF;
        expect_word(8'hFF, 1'b0);
        next_cycle();
        in_result = 10'h155;
`ifdef PE_DRAIN_SAT_EN
        expect_word(8'hFF, 1'b0);
`else
        expect_word(8'h55, 1'b0);
`endif
        next_cycle();
        in_valid = 1'b0;
        wait_drain("t4_drained");

        // 5: flush ends a short frame on the fifth beat.
        do_reset(1);
        m_axis_tready = 1'b0;
        start_run();
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(20 + i);
            expect_word(8'(20 + i), i == 4);
            next_cycle();
        end
        in_valid = 1'b0;
        enable   = 1'b0;
        next_cycle();
        next_cycle();
        m_axis_tready = 1'b1;
        wait_drain("t5_drained");
        repeat (2) next_cycle();
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(90 + i);
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        check("t5_idle_tvalid", m_axis_tvalid, 0);
        check("t5_idle_fifo_count", fifo_count, 0);
        check("t5_idle_overflow", overflow, 0);

        // 6: reset in the middle of a frame, then a clean 16-beat frame
        do_reset(1);
        start_run();
        beats_seen = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(30 + i);
            expect_word(8'(30 + i), 1'b0);
            next_cycle();
        end
        in_valid = 1'b0;
        check("t6_beats_before_rst", beats_seen, 3);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        @(negedge clk);
        check("t6_tvalid_after_rst", m_axis_tvalid, 0);
        check("t6_fifo_after_rst", fifo_count, 0);
        next_cycle();
        beats_seen = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_result = 10'(40 + i);
            expect_word(8'(40 + i), 1'b0);
            next_cycle();
        end
        in_valid = 1'b0;
        wait_drain("t6_drained");
        check("t6_frame_beats", beats_seen, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
